cache_mem_arb: RTL

CACHE_MEM_ARB -- requirements
Module: cache_mem_arb

---
 rtl/cache_mem_arb_pkg.sv | 20 ++
 rtl/cache_mem_arb_if.sv | 35 +++
 rtl/cache_mem_arb_pick.sv | 46 ++++
 rtl/cache_mem_arb.sv | 104 ++++++++++
 4 files changed

// File: rtl/cache_mem_arb_pkg.sv
// Shared types for the cache/memory arbiter: FSM state encoding, requester source encoding, default latency.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_t with S_IDLE/S_ISSUE/S_WAIT/S_RESP, src_t with SRC_I/SRC_D, MEM_LAT_DEF.
package arb_pkg;

  localparam int MEM_LAT_DEF = 4;

  typedef logic [1:0] state_t;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_t;

endpackage

// File: rtl/cache_mem_arb_if.sv
// Bundle of the I-cache/D-cache miss ports and the shared memory port.
// Latency: n/a (wires only).
// Backpressure: requests are held until done; the memory side stalls with mem_stall.
// Modports: master = arbiter (drives done/err/rdata and mem_*), slave = caches plus memory model.
interface cache_mem_arb_if;

  logic        ic_req;
  logic [15:0] ic_addr;
  logic        dc_req;
  logic [15:0] dc_addr;
  logic        dc_wr;
  logic [15:0] dc_wdata;
  logic        ic_done;
  logic        dc_done;
  logic        ic_err;
  logic        dc_err;
  logic [15:0] rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_stall;

  modport master (
    input  ic_req, ic_addr, dc_req, dc_addr, dc_wr, dc_wdata, mem_rdata, mem_stall,
    output ic_done, dc_done, ic_err, dc_err, rdata, mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    output ic_req, ic_addr, dc_req, dc_addr, dc_wr, dc_wdata, mem_rdata, mem_stall,
    input  ic_done, dc_done, ic_err, dc_err, rdata, mem_en, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_mem_arb_pick.sv
// Winner selection between the I-cache and D-cache requests (module arb_pick).
// Latency: combinational; the round-robin pointer updates on the grant edge.
// Backpressure: none; the loser simply keeps requesting.
// Ports: ic_req/dc_req in, any_req/win out; with ARB_RR_EN also clk, rst (active-low async), take.
// Config: ARB_RR_EN selects round-robin on ties, otherwise fixed D-cache priority with no state.
module arb_pick
  import arb_pkg::*;
(
`ifdef ARB_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic take,
`endif
  input  logic ic_req,
  input  logic dc_req,
  output logic any_req,
  output src_t win
);

  assign any_req = ic_req | dc_req;

`ifdef ARB_RR_EN
  // prefer_i=1 means the I-cache wins the next tie; reset favours the D-cache.
  logic prefer_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prefer_i <= 1'b0;
    end else if (take) begin
      prefer_i <= (win == SRC_D);
    end
  end

  always_comb begin
    win = SRC_I;
    if (ic_req && dc_req) begin
      win = prefer_i ? SRC_I : SRC_D;
    end else if (dc_req) begin
      win = SRC_D;
    end
  end
`else
  assign win = dc_req ? SRC_D : SRC_I;
`endif

endmodule

// File: rtl/cache_mem_arb.sv
// Arbitrates I-cache and D-cache misses onto one memory port, one transaction at a time.
// Latency: done MEM_LAT+2 cycles after the grant with no stall; unaligned requests finish 2 cycles after grant.
// Backpressure: mem_stall holds the access in ISSUE; losing/queued requesters wait with req held.
// Ports: clk, rst (async active-low), bus (cache_mem_arb_if.master). Param MEM_LAT 1..15.
// Config: ARB_RR_EN switches tie-breaking from fixed D-cache priority to round-robin.
module cache_mem_arb
  import arb_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  cache_mem_arb_if.master bus
);

  state_t      state;
  src_t        src_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        wr_q;
  logic [3:0]  cnt;
  logic        any_req;
  src_t        win;
  logic        grant;
  logic        issue_go;
  logic        resp;

  assign grant = (state == S_IDLE) && any_req;

  arb_pick u_pick (
`ifdef ARB_RR_EN
    .clk     (clk),
    .rst     (rst),
    .take    (grant),
`endif
    .ic_req  (bus.ic_req),
    .dc_req  (bus.dc_req),
    .any_req (any_req),
    .win     (win)
  );

  // Alignment is judged on the latched address, so an odd request spends its
  // ISSUE cycle with mem_en suppressed and goes straight on to RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      src_q   <= SRC_I;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            src_q   <= win;
            addr_q  <= (win == SRC_D) ? bus.dc_addr : bus.ic_addr;
            wr_q    <= (win == SRC_D) && bus.dc_wr;
            wdata_q <= (win == SRC_D) ? bus.dc_wdata : '0;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (addr_q[0]) begin
            state <= S_RESP;
          end else if (!bus.mem_stall) begin
            cnt   <= 4'(MEM_LAT - 1);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            rdata_q <= wr_q ? '0 : bus.mem_rdata;
            state   <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          // rdata only carries a value during the done cycle.
          rdata_q <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign issue_go      = (state == S_ISSUE) && !addr_q[0];
  assign bus.mem_en    = issue_go;
  assign bus.mem_wr    = issue_go && wr_q;
  assign bus.mem_addr  = issue_go ? addr_q : '0;
  assign bus.mem_wdata = issue_go ? wdata_q : '0;

  assign resp        = (state == S_RESP);
  assign bus.ic_done = resp && (src_q == SRC_I);
  assign bus.dc_done = resp && (src_q == SRC_D);
  assign bus.ic_err  = bus.ic_done && addr_q[0];
  assign bus.dc_err  = bus.dc_done && addr_q[0];
  assign bus.rdata   = rdata_q;

endmodule
